// File: rtl/piano_pkg.sv
// Shared types and constants for the piano note path.
package piano_pkg;

    localparam int unsigned NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    // Widest duration field any instance may use; entries are widened to this on read.
    localparam int unsigned DUR_MAX_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRec,
        StPlay
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0]    note;
        logic [DUR_MAX_W-1:0] dur;
    } entry_t;

endpackage

// File: rtl/note_ram.sv
// Simple dual-port entry buffer: one write port, one registered read port, no array reset.
module note_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and synchronous read share the clock edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/note_recorder.sv
// Records the controller note stream as run-length (note, duration) entries and replays it.
module note_recorder
    import piano_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 1_000_000,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned DUR_W       = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rec_start,
    input  logic                     play_start,
    input  logic                     stop,
    input  logic [NOTE_W-1:0]        note_in,
    output logic [NOTE_W-1:0]        note_out,
    output logic                     recording,
    output logic                     playing,
    output logic                     full,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   entry_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]        TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [DUR_MAX_W-1:0] DUR_SAT    = DUR_MAX_W'((32'd1 << DUR_W) - 32'd1);
    localparam logic [CW-1:0]        COUNT_FULL = CW'(DEPTH);

    state_e                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    // Accumulated duration while recording, remaining duration while playing.
    logic [DUR_MAX_W-1:0]  dur_q, dur_d;
    logic [NOTE_W-1:0]     cur_note_q, cur_note_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  done_q, done_d;
    logic [NOTE_W-1:0]     note_out_q, note_out_d;
    // Index of the next entry to put on note_out; also drives the RAM read address.
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    // prime: RAM read of entry 0 in flight; load: entry 0 ready to present.
    logic                  prime_q, prime_d;
    logic                  load_q, load_d;

    logic                  tick_wrap;
    logic [TW-1:0]         tick_inc;
    logic [CW-1:0]         count_inc;
    logic                  commit;
    logic                  advance;
    logic                  we;
    logic [NOTE_W+DUR_W-1:0] wr_word;
    logic [NOTE_W+DUR_W-1:0] rd_word;
    entry_t                rd_entry;

    assign tick_wrap = (tick_q == TICK_LAST);
    assign tick_inc  = tick_wrap ? '0 : tick_q + TW'(1);
    assign count_inc = count_q + CW'(1);
    assign wr_word   = {cur_note_q, dur_q[DUR_W-1:0]};
    assign rd_entry  = '{note: rd_word[DUR_W +: NOTE_W], dur: DUR_MAX_W'(rd_word[DUR_W-1:0])};

    // Next-state: commands first (stop > rec_start > play_start), then per-state behaviour.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        dur_d      = dur_q;
        cur_note_d = cur_note_q;
        count_d    = count_q;
        full_d     = full_q;
        done_d     = 1'b0;
        note_out_d = note_out_q;
        rd_ptr_d   = rd_ptr_q;
        prime_d    = prime_q;
        load_d     = load_q;
        commit     = 1'b0;
        advance    = 1'b0;

        if (stop) begin
            if (state_q == StRec && dur_q != '0 && count_q < COUNT_FULL) begin
                commit = 1'b1;
            end
            state_d    = StIdle;
            note_out_d = NOTE_REST;
            prime_d    = 1'b0;
            load_d     = 1'b0;
        end else if (rec_start) begin
            state_d    = StRec;
            count_d    = '0;
            full_d     = 1'b0;
            cur_note_d = note_in;
            dur_d      = '0;
            tick_d     = '0;
            note_out_d = NOTE_REST;
            prime_d    = 1'b0;
            load_d     = 1'b0;
        end else if (play_start) begin
            note_out_d = NOTE_REST;
            load_d     = 1'b0;
            if (count_q == '0) begin
                state_d = StIdle;
                done_d  = 1'b1;
                prime_d = 1'b0;
            end else begin
                state_d  = StPlay;
                rd_ptr_d = '0;
                prime_d  = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRec: begin
                    if (note_in != cur_note_q) begin
                        cur_note_d = note_in;
                        if (dur_q != '0) begin
                            // The partial tick of the finished note is dropped.
                            commit = 1'b1;
                            dur_d  = '0;
                            tick_d = '0;
                        end else begin
                            // Sub-tick glitch: the new note takes over the running tick.
                            tick_d = tick_inc;
                            dur_d  = tick_wrap ? DUR_MAX_W'(1) : '0;
                        end
                    end else if (dur_q == DUR_SAT) begin
                        // Split a long note without losing time.
                        commit = 1'b1;
                        tick_d = tick_inc;
                        dur_d  = tick_wrap ? DUR_MAX_W'(1) : '0;
                    end else begin
                        tick_d = tick_inc;
                        if (tick_wrap) begin
                            dur_d = dur_q + DUR_MAX_W'(1);
                        end
                    end
                end
                StPlay: begin
                    if (prime_q) begin
                        prime_d = 1'b0;
                        load_d  = 1'b1;
                    end else if (load_q) begin
                        load_d  = 1'b0;
                        advance = 1'b1;
                    end else begin
                        tick_d = tick_inc;
                        if (tick_wrap) begin
                            if (dur_q == DUR_MAX_W'(1)) begin
                                advance = 1'b1;
                            end else begin
                                dur_d = dur_q - DUR_MAX_W'(1);
                            end
                        end
                    end
                    // rd_entry already holds entry rd_ptr_q (prefetched), so changes are gapless.
                    if (advance) begin
                        if (rd_ptr_q < count_q) begin
                            note_out_d = rd_entry.note;
                            dur_d      = rd_entry.dur;
                            tick_d     = '0;
                            rd_ptr_d   = rd_ptr_q + CW'(1);
                        end else begin
                            state_d    = StIdle;
                            note_out_d = NOTE_REST;
                            done_d     = 1'b1;
                        end
                    end
                end
                StIdle: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        if (commit) begin
            count_d = count_inc;
            if (count_inc == COUNT_FULL) begin
                full_d  = 1'b1;
                state_d = StIdle;
            end
        end
    end

    assign we = commit;

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            dur_q      <= '0;
            cur_note_q <= NOTE_REST;
            count_q    <= '0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            note_out_q <= NOTE_REST;
            rd_ptr_q   <= '0;
            prime_q    <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            cur_note_q <= cur_note_d;
            count_q    <= count_d;
            full_q     <= full_d;
            done_q     <= done_d;
            note_out_q <= note_out_d;
            rd_ptr_q   <= rd_ptr_d;
            prime_q    <= prime_d;
            load_q     <= load_d;
        end
    end

    note_ram #(
        .DEPTH(DEPTH),
        .WIDTH(NOTE_W + DUR_W),
        .AW   (AW)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (we),
        .waddr_i(count_q[AW-1:0]),
        .wdata_i(wr_word),
        .raddr_i(rd_ptr_d[AW-1:0]),
        .rdata_o(rd_word)
    );

    assign note_out    = note_out_q;
    assign recording   = (state_q == StRec);
    assign playing     = (state_q == StPlay);
    assign full        = full_q;
    assign done        = done_q;
    assign entry_count = count_q;

endmodule
